// File: rtl/div_issue_ctrl_pkg.sv
// Purpose: shared types for the divide issue sequencer (decode bundle, FSM state).
// Latency: n/a (types only).
// Backpressure: n/a.
package div_issue_ctrl_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int OPND_W     = 32;

  // Decode bits the divider needs alongside the operands.
  typedef struct packed {
    logic is_signed;
    logic is_word;
    logic set_oe;
    logic set_rc;
  } div_decode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } div_issue_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin pick of the first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
//   req       : request vector
//   ptr       : highest-priority index for this cycle
//   grant     : one-hot grant (zero when no request)
//   grant_idx : binary index of the granted bit
//   any       : at least one request present
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int W = $clog2(N);

  int probe;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    probe     = 0;
    for (int i = 0; i < N; i++) begin
      probe = (int'(ptr) + i) % N;
      if (!any && req[probe]) begin
        any          = 1'b1;
        grant[probe] = 1'b1;
        grant_idx    = W'(probe);
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Purpose: round-robin issue of one op at a time to the non-pipelined divider, steering its result handshake.
// Latency: grant in IDLE at t, div_valid at t+1; next grant possible the cycle after the result handshake.
// Backpressure: div_valid/payload held until div_ready; divider result held off while res_ready is low.
//   req_*       : per-requester op (valid/ready + flat payload vectors)
//   div_*       : issue handshake and latched payload toward the divider
//   div_out_*   : result handshake from the divider (tag only; data bypasses this block)
//   res_*       : result handshake toward the result bus
//   flush, busy : kill current op / FSM not idle
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*RS_ID_WIDTH-1:0]     req_rs_id,
  input  logic [NUM_REQ*GPR_ADDR_W-1:0]      req_reg_addr,
  input  logic [NUM_REQ*OPND_W-1:0]          req_op1,
  input  logic [NUM_REQ*OPND_W-1:0]          req_op2,
  input  div_decode_t [NUM_REQ-1:0]          req_control,
  output logic                               div_valid,
  input  logic                               div_ready,
  output logic [RS_ID_WIDTH-1:0]             div_rs_id,
  output logic [GPR_ADDR_W-1:0]              div_reg_addr,
  output logic [OPND_W-1:0]                  div_op1,
  output logic [OPND_W-1:0]                  div_op2,
  output div_decode_t                        div_control,
  input  logic                               div_out_valid,
  output logic                               div_out_ready,
  input  logic [RS_ID_WIDTH-1:0]             div_out_rs_id,
  output logic                               res_valid,
  input  logic                               res_ready,
  input  logic                               flush,
  output logic                               busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  div_issue_state_t        state;
  div_issue_state_t        state_nxt;
  logic [IDX_W-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]      arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic                    grant_fire;
  logic                    tag_match;

  // The in-flight tag doubles as the issued rs_id.
  logic [RS_ID_WIDTH-1:0]  inflight_id;
  logic [GPR_ADDR_W-1:0]   pl_reg_addr;
  logic [OPND_W-1:0]       pl_op1;
  logic [OPND_W-1:0]       pl_op2;
  div_decode_t             pl_control;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign grant_fire = (state == S_IDLE) && !flush && arb_any;
  assign tag_match  = (div_out_rs_id == inflight_id);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Payload capture and rotation pointer; only move on an accepted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      inflight_id <= '0;
      pl_reg_addr <= '0;
      pl_op1      <= '0;
      pl_op2      <= '0;
      pl_control  <= '0;
    end else if (grant_fire) begin
      rr_ptr      <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
      inflight_id <= req_rs_id[int'(arb_idx)*RS_ID_WIDTH +: RS_ID_WIDTH];
      pl_reg_addr <= req_reg_addr[int'(arb_idx)*GPR_ADDR_W +: GPR_ADDR_W];
      pl_op1      <= req_op1[int'(arb_idx)*OPND_W +: OPND_W];
      pl_op2      <= req_op2[int'(arb_idx)*OPND_W +: OPND_W];
      pl_control  <= req_control[arb_idx];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_fire) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // A flush racing an accepted issue must still swallow its result.
        if (div_ready)  state_nxt = flush ? S_DRAIN : S_WAIT;
        else if (flush) state_nxt = S_IDLE;
      end
      S_WAIT: begin
        // A handshake in the flush cycle wins: the result was delivered.
        if (div_out_valid && div_out_ready) state_nxt = S_IDLE;
        else if (flush)                     state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (div_out_valid && tag_match) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready     = '0;
    div_valid     = 1'b0;
    res_valid     = 1'b0;
    div_out_ready = 1'b0;
    case (state)
      S_IDLE: begin
        // rst gating keeps req_ready low while reset is held, even with requests pending.
        if (!flush && !rst) req_ready = arb_grant;
      end
      S_ISSUE: begin
        div_valid = 1'b1;
      end
      S_WAIT: begin
        res_valid     = div_out_valid && tag_match;
        div_out_ready = tag_match && res_ready;
      end
      S_DRAIN: begin
        div_out_ready = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy         = (state != S_IDLE);
  assign div_rs_id    = inflight_id;
  assign div_reg_addr = pl_reg_addr;
  assign div_op1      = pl_op1;
  assign div_op2      = pl_op2;
  assign div_control  = pl_control;

  // A result for another tag while waiting means the divider and this block disagree.
  a_wait_tag_match: assert property (@(posedge clk) disable iff (rst)
    (state == S_WAIT && div_out_valid) |-> tag_match);

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [TW-1:0]     tag_a  [N];
  logic [4:0]        addr_a [N];
  logic [31:0]       op1_a  [N];
  logic [31:0]       op2_a  [N];
  div_decode_t       ctl_a  [N];
  logic [N*TW-1:0]   req_rs_id;
  logic [N*5-1:0]    req_reg_addr;
  logic [N*32-1:0]   req_op1;
  logic [N*32-1:0]   req_op2;
  div_decode_t [N-1:0] req_control;
  logic              div_valid, div_ready;
  logic [TW-1:0]     div_rs_id;
  logic [4:0]        div_reg_addr;
  logic [31:0]       div_op1, div_op2;
  div_decode_t       div_control;
  logic              div_out_valid, div_out_ready;
  logic [TW-1:0]     div_out_rs_id;
  logic              res_valid, res_ready, flush, busy;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_rs_id[i*TW +: TW]  = tag_a[i];
      req_reg_addr[i*5 +: 5] = addr_a[i];
      req_op1[i*32 +: 32]    = op1_a[i];
      req_op2[i*32 +: 32]    = op2_a[i];
      req_control[i]         = ctl_a[i];
    end
  end

  div_issue_ctrl #(.NUM_REQ(N), .RS_ID_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs_id(req_rs_id),
    .req_reg_addr(req_reg_addr), .req_op1(req_op1), .req_op2(req_op2),
    .req_control(req_control),
    .div_valid(div_valid), .div_ready(div_ready), .div_rs_id(div_rs_id),
    .div_reg_addr(div_reg_addr), .div_op1(div_op1), .div_op2(div_op2),
    .div_control(div_control),
    .div_out_valid(div_out_valid), .div_out_ready(div_out_ready),
    .div_out_rs_id(div_out_rs_id),
    .res_valid(res_valid), .res_ready(res_ready), .flush(flush), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1; outputs are sampled at the following negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_inputs();
    req_valid = '0; flush = 1'b0; div_ready = 1'b0;
    div_out_valid = 1'b0; div_out_rs_id = '0; res_ready = 1'b0;
  endtask

  task automatic fixed_payload();
    tag_a  = '{5'd7, 5'd8, 5'd9, 5'd10};
    addr_a = '{5'd1, 5'd2, 5'd3, 5'd4};
    op1_a  = '{32'd40, 32'd50, 32'd100, 32'd60};
    op2_a  = '{32'd3, 32'd5, 32'd7, 32'd9};
    for (int i = 0; i < N; i++) ctl_a[i] = div_decode_t'(4'(i + 5));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] rv;
    logic       fl, dr, dov;
    logic [4:0] tag;
    logic       rr;
    logic [3:0] e_rq;
    logic       e_dv, e_rv, e_dor, e_busy;
  } vec_t;

  vec_t tbl [13];

  // Model state for the randomized run: the op accepted but not yet issued,
  // the op issued whose result is outstanding, and whether that result is to be discarded.
  int          m_ptr;
  bit          m_pend, m_out, m_swal;
  logic [4:0]  m_id, m_addr;
  logic [31:0] m_op1, m_op2;

  initial begin
    logic [3:0] one;
    int         order [5];
    int         g;
    logic [3:0] e_rq;
    bit         idle, match, e_dor;

    one = 4'b0001;
    clear_inputs();
    fixed_payload();

    //           rv     fl dr dov tag rr  | e_rq   dv rv dor busy
    tbl[0]  = '{4'b0000, 0, 0, 0, 5'd0, 0, 4'b0000, 0, 0, 0, 0};
    tbl[1]  = '{4'b0100, 0, 0, 0, 5'd0, 0, 4'b0100, 0, 0, 0, 0};
    tbl[2]  = '{4'b0000, 0, 1, 0, 5'd0, 0, 4'b0000, 1, 0, 0, 1};
    tbl[3]  = '{4'b0000, 0, 0, 0, 5'd0, 0, 4'b0000, 0, 0, 0, 1};
    tbl[4]  = '{4'b0000, 0, 0, 1, 5'd9, 1, 4'b0000, 0, 1, 1, 1};
    tbl[5]  = '{4'b1111, 0, 0, 0, 5'd0, 0, 4'b1000, 0, 0, 0, 0};
    tbl[6]  = '{4'b1111, 1, 0, 0, 5'd0, 0, 4'b0000, 1, 0, 0, 1};
    tbl[7]  = '{4'b1111, 1, 0, 0, 5'd0, 0, 4'b0000, 0, 0, 0, 0};
    tbl[8]  = '{4'b1111, 0, 0, 0, 5'd0, 0, 4'b0001, 0, 0, 0, 0};
    tbl[9]  = '{4'b1111, 1, 1, 0, 5'd0, 0, 4'b0000, 1, 0, 0, 1};
    tbl[10] = '{4'b0000, 0, 0, 0, 5'd0, 0, 4'b0000, 0, 0, 1, 1};
    tbl[11] = '{4'b0000, 0, 0, 1, 5'd7, 0, 4'b0000, 0, 0, 1, 1};
    tbl[12] = '{4'b1111, 0, 0, 0, 5'd0, 0, 4'b0010, 0, 0, 0, 0};

    // ---------------- reset state ----------------
    do_reset();
    settle();
    check("rst div_op1", div_op1, 0);
    check("rst div_rs_id", div_rs_id, 0);

    // ---------------- table vectors ----------------
    for (int r = 0; r < 13; r++) begin
      req_valid = tbl[r].rv; flush = tbl[r].fl; div_ready = tbl[r].dr;
      div_out_valid = tbl[r].dov; div_out_rs_id = tbl[r].tag; res_ready = tbl[r].rr;
      settle();
      check($sformatf("vec%0d req_ready", r), req_ready, tbl[r].e_rq);
      check($sformatf("vec%0d div_valid", r), div_valid, tbl[r].e_dv);
      check($sformatf("vec%0d res_valid", r), res_valid, tbl[r].e_rv);
      check($sformatf("vec%0d div_out_ready", r), div_out_ready, tbl[r].e_dor);
      check($sformatf("vec%0d busy", r), busy, tbl[r].e_busy);
      cyc();
    end

    // ---------------- single op with backpressure ----------------
    do_reset();
    req_valid = 4'b0100;
    settle();
    check("single req_ready", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("bp%0d div_valid", k), div_valid, 1);
      check($sformatf("bp%0d op1", k), div_op1, 100);
      check($sformatf("bp%0d op2", k), div_op2, 7);
      check($sformatf("bp%0d rs_id", k), div_rs_id, 9);
      check($sformatf("bp%0d reg_addr", k), div_reg_addr, 3);
      check($sformatf("bp%0d control", k), div_control, ctl_a[2]);
      cyc();
    end
    div_ready = 1'b1;
    settle();
    check("single issue div_valid", div_valid, 1);
    cyc();
    div_ready = 1'b0;
    div_out_valid = 1'b1; div_out_rs_id = 5'd9; res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("rbp%0d res_valid", k), res_valid, 1);
      check($sformatf("rbp%0d div_out_ready", k), div_out_ready, 0);
      check($sformatf("rbp%0d busy", k), busy, 1);
      cyc();
    end
    res_ready = 1'b1;
    settle();
    check("single res_valid", res_valid, 1);
    check("single div_out_ready", div_out_ready, 1);
    cyc();
    div_out_valid = 1'b0; res_ready = 1'b0;
    settle();
    check("single back idle", busy, 0);
    cyc();

    // ---------------- round robin ----------------
    do_reset();
    order = '{0, 1, 2, 3, 0};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("rr%0d grant", k), req_ready, one << order[k]);
      cyc();
      div_ready = 1'b1;
      settle();
      check($sformatf("rr%0d issued tag", k), div_rs_id, tag_a[order[k]]);
      cyc();
      div_ready = 1'b0;
      div_out_valid = 1'b1; div_out_rs_id = tag_a[order[k]]; res_ready = 1'b1;
      settle();
      check($sformatf("rr%0d res_valid", k), res_valid, 1);
      cyc();
      div_out_valid = 1'b0; res_ready = 1'b0;
    end

    // ---------------- flush in WAIT, result 10 cycles later ----------------
    do_reset();
    req_valid = 4'b0001;
    cyc();
    req_valid = '0; div_ready = 1'b1;
    cyc();
    div_ready = 1'b0; flush = 1'b1;
    settle();
    check("fw flush busy", busy, 1);
    cyc();
    flush = 1'b0; res_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      settle();
      check($sformatf("fw%0d div_out_ready", k), div_out_ready, 1);
      check($sformatf("fw%0d res_valid", k), res_valid, 0);
      cyc();
    end
    div_out_valid = 1'b1; div_out_rs_id = 5'd7;
    settle();
    check("fw swallow res_valid", res_valid, 0);
    check("fw swallow div_out_ready", div_out_ready, 1);
    check("fw swallow busy", busy, 1);
    cyc();
    div_out_valid = 1'b0; res_ready = 1'b0;
    settle();
    check("fw back idle", busy, 0);
    cyc();

    // ---------------- flush coincident with result ----------------
    do_reset();
    req_valid = 4'b0001;
    cyc();
    req_valid = '0; div_ready = 1'b1;
    cyc();
    div_ready = 1'b0; flush = 1'b1;
    div_out_valid = 1'b1; div_out_rs_id = 5'd7; res_ready = 1'b1;
    settle();
    check("fr res_valid", res_valid, 1);
    check("fr div_out_ready", div_out_ready, 1);
    cyc();
    flush = 1'b0; div_out_valid = 1'b0; res_ready = 1'b0;
    settle();
    check("fr idle not drain", busy, 0);
    cyc();

    // ---------------- async reset mid-WAIT ----------------
    do_reset();
    req_valid = 4'b0001;
    cyc();
    req_valid = '0; div_ready = 1'b1;
    cyc();
    div_ready = 1'b0;
    div_out_valid = 1'b1; div_out_rs_id = 5'd7; res_ready = 1'b0;
    #1;
    check("ar pre res_valid", res_valid, 1);
    check("ar pre busy", busy, 1);
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    check("ar res_valid", res_valid, 0);
    check("ar busy", busy, 0);
    check("ar div_valid", div_valid, 0);
    check("ar div_out_ready", div_out_ready, 0);
    check("ar req_ready", req_ready, 0);
    check("ar op1", div_op1, 0);
    check("ar rs_id", div_rs_id, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; div_out_valid = 1'b0;
    settle();
    check("ar first grant", req_ready, 4'b0001);
    cyc();

    // ---------------- randomized against model ----------------
    do_reset();
    m_ptr = 0; m_pend = 0; m_out = 0; m_swal = 0;
    m_id = '0; m_addr = '0; m_op1 = '0; m_op2 = '0;
    for (int c = 0; c < 1500; c++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        tag_a[i] = 5'($urandom); addr_a[i] = 5'($urandom);
        op1_a[i] = $urandom;     op2_a[i] = $urandom;
        ctl_a[i] = div_decode_t'(4'($urandom));
      end
      flush         = ($urandom_range(0, 11) == 0);
      div_ready     = ($urandom_range(0, 2) != 0);
      res_ready     = ($urandom_range(0, 3) != 0);
      div_out_valid = ($urandom_range(0, 2) == 0);
      if (m_out && !m_swal)     div_out_rs_id = m_id;
      else if (m_out && m_swal) div_out_rs_id = ($urandom_range(0, 1) != 0) ? m_id : m_id + 5'd1;
      else                      div_out_rs_id = 5'($urandom);
      settle();

      idle  = !m_pend && !m_out;
      match = (div_out_rs_id == m_id);
      g = -1;
      if (idle && !flush) begin
        for (int i = 0; i < N; i++) begin
          if (g < 0 && req_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        end
      end
      e_rq  = (g >= 0) ? (one << g) : 4'b0000;
      e_dor = m_out && (m_swal || (match && res_ready));

      check($sformatf("rnd%0d req_ready", c), req_ready, e_rq);
      check($sformatf("rnd%0d div_valid", c), div_valid, m_pend);
      check($sformatf("rnd%0d res_valid", c), res_valid, m_out && !m_swal && div_out_valid && match);
      check($sformatf("rnd%0d div_out_ready", c), div_out_ready, e_dor);
      check($sformatf("rnd%0d busy", c), busy, !idle);
      if (m_pend) begin
        check($sformatf("rnd%0d rs_id", c), div_rs_id, m_id);
        check($sformatf("rnd%0d op1", c), div_op1, m_op1);
        check($sformatf("rnd%0d op2", c), div_op2, m_op2);
        check($sformatf("rnd%0d reg_addr", c), div_reg_addr, m_addr);
      end

      if (g >= 0) begin
        m_pend = 1; m_id = tag_a[g]; m_addr = addr_a[g];
        m_op1 = op1_a[g]; m_op2 = op2_a[g];
        m_ptr = (g + 1) % N;
      end else if (m_pend) begin
        if (div_ready) begin
          m_pend = 0; m_out = 1; m_swal = flush;
        end else if (flush) begin
          m_pend = 0;
        end
      end else if (m_out && !m_swal) begin
        if (div_out_valid && e_dor) m_out = 0;
        else if (flush)             m_swal = 1;
      end else if (m_out && m_swal) begin
        if (div_out_valid && match) begin
          m_out = 0; m_swal = 0;
        end
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Sequencer sitting between the divide reservation-station entries and the iterative divide unit. It arbitrates round-robin among `NUM_REQ` requesters and issues one operation at a time, because the divider is not pipelined. It tracks the single in-flight tag and routes the divider's result handshake to the result bus. On flush it abandons an un-issued op, or swallows the returning result of an issued one.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `RS_ID_WIDTH`, default 5: tag width, matching the divide unit.
- `clk` in, 1: clock, rising edge.
- `rst` in, 1: reset. Asynchronous, active-high.
- `req_valid` in, NUM_REQ: per-requester op valid.
- `req_ready` out, NUM_REQ: per-requester accept; one-hot or zero.
- `req_rs_id` in, NUM_REQ×RS_ID_WIDTH: per-requester tag.
- `req_reg_addr` in, NUM_REQ×5: per-requester destination GPR.
- `req_op1` in, NUM_REQ×32: dividend.
- `req_op2` in, NUM_REQ×32: divisor.
- `req_control` in, NUM_REQ×div_decode_t: per-requester decode.
- `div_valid` out, 1: issue strobe to the divider.
- `div_ready` in, 1: divider accepts.
- `div_rs_id` out, RS_ID_WIDTH; `div_reg_addr` out, 5; `div_op1` out, 32; `div_op2` out, 32; `div_control` out, div_decode_t: latched issue payload.
- `div_out_valid` in, 1: divider result valid.
- `div_out_ready` out, 1: result accept toward the divider.
- `div_out_rs_id` in, RS_ID_WIDTH: tag of the returning result.
- `res_valid` out, 1: result to the result bus.
- `res_ready` in, 1: result bus accepts.
- `flush` in, 1: kill the current op.
- `busy` out, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - If any `req_valid`, grant the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - Latch the payload and `inflight_id`; set `rr_ptr <= (g+1) mod NUM_REQ`; go to ISSUE.
  - `flush` in IDLE suppresses the grant for that cycle: `req_ready` is all zero.
- ISSUE:
  - `div_valid=1` with a stable payload.
  - On `div_ready`, go to WAIT.
  - On `flush` without `div_ready`, go to IDLE; nothing was issued.
  - On `flush` with `div_ready`, go to DRAIN; the op was issued.
- WAIT:
  - `res_valid = div_out_valid && div_out_rs_id==inflight_id`.
  - `div_out_ready = res_ready` when the tag matches; otherwise 0.
  - When `div_out_valid && div_out_ready`, go to IDLE.
  - On `flush`, go to DRAIN. If the result handshake completes in the same cycle as `flush`, the result counts as delivered and the FSM goes to IDLE.
- DRAIN:
  - `res_valid=0`, `div_out_ready=1`.
  - A matching-tag result is swallowed, then the FSM goes to IDLE.
  - `flush` in DRAIN has no further effect.
- Result data and cr0/xer bypass this block. Only the handshake is steered.
- Tag mismatch while in WAIT is a protocol error. The result is not acknowledged, and an assertion fires in simulation.
- `req_ready` is zero outside IDLE. Throughput is at most one op per divide latency plus 2 cycles.

## Timing
- Reset state, asynchronous:
  - FSM=IDLE, `rr_ptr=0`, payload registers 0, `inflight_id=0`.
  - Outputs `div_valid=0`, `res_valid=0`, `div_out_ready=0`, `req_ready=0`, `busy=0`.
- Grant to `div_valid`: 1 cycle. The grant happens in IDLE at cycle t; `div_valid` rises at t+1.
- `div_valid` is held until `div_ready`. The payload does not change while `div_valid` is high.
- Back-to-back: after the result handshake at cycle t, IDLE at t+1 can grant the next op.
- Reset mid-operation returns to IDLE at once. The divider must be reset by the same `rst`; no DRAIN is performed.

## Structure
- `ppc_types` gains `div_issue_state_t` (IDLE, ISSUE, WAIT, DRAIN) as a 2-bit enum. It reuses `div_decode_t`.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req`, `ptr`. Outputs: one-hot `grant`, `grant_idx`, `any`.
  - Purely combinational, so it can be reused by other unit schedulers.
- FSM, payload registers and the tag comparison live in `div_issue_ctrl`. Estimated 200–300 lines.

## Test plan
- Single op: `req_valid[2]=1`, op1=100, op2=7, tag 9, `div_ready` high.
  - `req_ready[2]` pulses at t; `div_valid` at t+1 with op1=100, op2=7, `rs_id`=9.
  - Return a tag-9 result with `res_ready=1` → one `res_valid` pulse; FSM back to IDLE.
- Round-robin: all 4 requesters valid continuously, `rr_ptr=0`.
  - Grant order is 0, 1, 2, 3, 0. No requester is granted twice before the others.
- Backpressure:
  - `div_ready` held low 5 cycles → `div_valid` and payload stable for all 5 cycles.
  - `res_ready` low 3 cycles while the result is valid → `div_out_ready` low for those 3 cycles, and no state change.
- Flush in ISSUE with `div_ready=0` → IDLE next cycle, no result expected; the next grant goes to the next requester in rotation.
- Flush in WAIT:
  - Result with the matching tag arrives 10 cycles later → `res_valid` stays 0, `div_out_ready=1`, then IDLE.
  - A result arriving in the same cycle as `flush` with `res_ready=1` is delivered.
- Async reset asserted mid-WAIT (between clock edges) → all outputs 0 immediately, `rr_ptr=0`; after release, the first grant goes to the lowest valid index.
